ipsxb_fft_multi_ch_test_ctrl: RTL and testbench



---
 rtl/ipsxb_fft_multi_ch_test_ctrl.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_ipsxb_fft_multi_ch_test_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ipsxb_fft_multi_ch_test_ctrl.sv
// ipsxb_fft_multi_ch_test_ctrl
// Purpose : onboard test sequencer for the multi-channel FFT example design.
//           It debounces a start button, launches runs to the per-channel
//           frame_gen/frame_chk pairs in single, N-loop or continuous mode,
//           and keeps the per-channel error, timeout and run/fail counters
//           that drive the board LEDs.
// Latency : the start edge is seen 2 enabled cycles after the pin changes.
//           o_start_pulse follows the edge cycle by DB_CNT_MAX enabled cycles.
//           Consecutive runs are separated by one EVAL cycle plus GAP_CYCLES.
// Flow    : no backpressure. i_aclken=0 freezes every register, so a pulse
//           stays high until the next enabled cycle.
//
// Ports
//   i_clk, i_rstn     clock, asynchronous active-low reset
//   i_aclken          clock enable that qualifies every state update
//   i_start_test      raw start button (asynchronous, active-high)
//   i_stop            level request to end the current sequence
//   i_mode            00 single, 01 loop i_loop_num runs, 10 continuous, 11 single
//   i_loop_num        run count for loop mode (0 behaves as 1)
//   i_chk_finished    per-channel checker finished flags
//   i_err             per-channel checker error
//   i_alm             per-channel FFT alarm, channel c on [3c+2:3c]
//   o_start_pulse     one-enabled-cycle run launch
//   o_busy            sequencer is not idle (registered)
//   o_err, o_err_any  sticky per-channel error of the current/last run, and its OR
//   o_timeout         sticky, the last run timed out
//   o_run_cnt         completed runs, saturating
//   o_fail_cnt        failed runs, saturating
module ipsxb_fft_multi_ch_test_ctrl #(
  parameter int NUM_CH         = 2,
  parameter int DB_CNT_MAX     = 2048,
  parameter int DB_CNT_W       = 12,
  parameter int GAP_CYCLES     = 64,
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int TO_W           = 21,
  parameter int LOOP_W         = 8,
  parameter int CNT_W          = 16,
  parameter bit STOP_ON_FAIL   = 1'b0
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  input  logic                i_aclken,
  input  logic                i_start_test,
  input  logic                i_stop,
  input  logic [1:0]          i_mode,
  input  logic [LOOP_W-1:0]   i_loop_num,
  input  logic [NUM_CH-1:0]   i_chk_finished,
  input  logic [NUM_CH-1:0]   i_err,
  input  logic [3*NUM_CH-1:0] i_alm,
  output logic                o_start_pulse,
  output logic                o_busy,
  output logic [NUM_CH-1:0]   o_err,
  output logic                o_err_any,
  output logic                o_timeout,
  output logic [CNT_W-1:0]    o_run_cnt,
  output logic [CNT_W-1:0]    o_fail_cnt
);

  // Gap counter only needs to reach GAP_CYCLES-1.
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  localparam logic [DB_CNT_W-1:0] DB_ONE   = DB_CNT_W'(1);
  localparam logic [DB_CNT_W-1:0] DB_LAST  = DB_CNT_W'(DB_CNT_MAX - 1);
  localparam logic [GAP_W-1:0]    GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [TO_W-1:0]     TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [LOOP_W-1:0]   LOOP_ONE = LOOP_W'(1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DEBOUNCE = 3'd1,
    S_LAUNCH   = 3'd2,
    S_WAIT_ARM = 3'd3,
    S_WAIT_CHK = 3'd4,
    S_EVAL     = 3'd5,
    S_GAP      = 3'd6
  } state_t;

  state_t              state_q,    state_d;
  logic [2:0]          sync_q,     sync_d;
  logic [DB_CNT_W-1:0] db_cnt_q,   db_cnt_d;
  logic [GAP_W-1:0]    gap_cnt_q,  gap_cnt_d;
  logic [TO_W-1:0]     to_cnt_q,   to_cnt_d;
  logic [LOOP_W-1:0]   run_idx_q,  run_idx_d;
  logic [LOOP_W-1:0]   loop_num_q, loop_num_d;
  logic [1:0]          mode_q,     mode_d;
  logic                stop_req_q, stop_req_d;
  logic [NUM_CH-1:0]   err_q,      err_d;
  logic                timeout_q,  timeout_d;
  logic [CNT_W-1:0]    run_cnt_q,  run_cnt_d;
  logic [CNT_W-1:0]    fail_cnt_q, fail_cnt_d;
  logic                busy_q;

  logic [NUM_CH-1:0]   alm_hit;
  logic                start_edge;
  logic                err_any;
  logic                run_failed;
  logic                mode_single;
  logic                mode_loop;
  logic [LOOP_W-1:0]   loop_max;
  logic [LOOP_W-1:0]   run_idx_inc;
  logic                seq_done;

  // Any of the three alarm bits of a channel counts as an error for it.
  always_comb begin
    alm_hit = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      alm_hit[c] = |i_alm[3*c +: 3];
    end
  end

  // sync_q[0] is the metastability stage; the edge is taken between the
  // two settled stages so a held button after reset (all ones) is silent.
  assign start_edge  = sync_q[1] & ~sync_q[2];

  assign err_any     = |err_q;
  assign run_failed  = err_any | timeout_q;
  assign mode_single = (mode_q == 2'b00) || (mode_q == 2'b11);
  assign mode_loop   = (mode_q == 2'b01);
  assign loop_max    = (loop_num_q == '0) ? LOOP_ONE : loop_num_q;
  assign run_idx_inc = run_idx_q + LOOP_ONE;

  // A live i_stop in EVAL is treated as pending as well as a latched one.
  assign seq_done = mode_single
                 || stop_req_q
                 || i_stop
                 || timeout_q
                 || (STOP_ON_FAIL && run_failed)
                 || (mode_loop && (run_idx_inc == loop_max));

  always_comb begin
    state_d    = state_q;
    sync_d     = {sync_q[1:0], i_start_test};
    db_cnt_d   = db_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    to_cnt_d   = to_cnt_q;
    run_idx_d  = run_idx_q;
    loop_num_d = loop_num_q;
    mode_d     = mode_q;
    stop_req_d = stop_req_q;
    timeout_d  = timeout_q;
    run_cnt_d  = run_cnt_q;
    fail_cnt_d = fail_cnt_q;
    // Error flags are sticky in every state; LAUNCH overrides below.
    err_d      = err_q | i_err | alm_hit;

    case (state_q)
      S_IDLE: begin
        if (start_edge) begin
          state_d  = S_DEBOUNCE;
          db_cnt_d = DB_ONE;
        end
      end

      S_DEBOUNCE: begin
        if (i_stop) begin
          state_d = S_IDLE;
        end else if (db_cnt_q == DB_LAST) begin
          state_d    = S_LAUNCH;
          db_cnt_d   = '0;
          run_idx_d  = '0;
          // Mode and loop count are frozen for the whole sequence.
          mode_d     = i_mode;
          loop_num_d = i_loop_num;
        end else begin
          db_cnt_d = db_cnt_q + DB_ONE;
        end
      end

      S_LAUNCH: begin
        // Clear wins over a same-cycle error from the previous run.
        err_d     = '0;
        timeout_d = 1'b0;
        to_cnt_d  = '0;
        state_d   = S_WAIT_ARM;
        if (i_stop) begin
          stop_req_d = 1'b1;
        end
      end

      S_WAIT_ARM: begin
        if (i_stop) begin
          stop_req_d = 1'b1;
        end
        // Checkers must first drop finished to show they took the launch.
        if (to_cnt_q == TO_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_EVAL;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
          if (i_chk_finished == '0) begin
            state_d = S_WAIT_CHK;
          end
        end
      end

      S_WAIT_CHK: begin
        if (i_stop) begin
          stop_req_d = 1'b1;
        end
        if (to_cnt_q == TO_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_EVAL;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
          if (&i_chk_finished) begin
            state_d = S_EVAL;
          end
        end
      end

      S_EVAL: begin
        run_idx_d = run_idx_inc;
        if (!(&run_cnt_q)) begin
          run_cnt_d = run_cnt_q + CNT_W'(1);
        end
        if (run_failed && !(&fail_cnt_q)) begin
          fail_cnt_d = fail_cnt_q + CNT_W'(1);
        end
        if (seq_done) begin
          state_d = S_IDLE;
        end else begin
          state_d   = S_GAP;
          gap_cnt_d = '0;
        end
      end

      S_GAP: begin
        if (i_stop) begin
          state_d = S_IDLE;
        end else if (gap_cnt_q == GAP_LAST) begin
          state_d = S_LAUNCH;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A stop request never outlives the sequence it was raised in.
    if (state_d == S_IDLE) begin
      stop_req_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q    <= S_IDLE;
      sync_q     <= 3'b111;
      db_cnt_q   <= '0;
      gap_cnt_q  <= '0;
      to_cnt_q   <= '0;
      run_idx_q  <= '0;
      loop_num_q <= '0;
      mode_q     <= 2'b00;
      stop_req_q <= 1'b0;
      err_q      <= '0;
      timeout_q  <= 1'b0;
      run_cnt_q  <= '0;
      fail_cnt_q <= '0;
      busy_q     <= 1'b0;
    end else if (i_aclken) begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      db_cnt_q   <= db_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      to_cnt_q   <= to_cnt_d;
      run_idx_q  <= run_idx_d;
      loop_num_q <= loop_num_d;
      mode_q     <= mode_d;
      stop_req_q <= stop_req_d;
      err_q      <= err_d;
      timeout_q  <= timeout_d;
      run_cnt_q  <= run_cnt_d;
      fail_cnt_q <= fail_cnt_d;
      busy_q     <= (state_d != S_IDLE);
    end
  end

  // LAUNCH lasts exactly one enabled cycle, so decoding the registered
  // state gives a glitch-free pulse that also freezes with i_aclken.
  assign o_start_pulse = (state_q == S_LAUNCH);
  assign o_busy        = busy_q;
  assign o_err         = err_q;
  assign o_err_any     = err_any;
  assign o_timeout     = timeout_q;
  assign o_run_cnt     = run_cnt_q;
  assign o_fail_cnt    = fail_cnt_q;

endmodule

// File: tb/tb_ipsxb_fft_multi_ch_test_ctrl.sv
module tb_ipsxb_fft_multi_ch_test_ctrl;

  localparam int DBM  = 16;
  localparam int GAPC = 8;
  localparam int TOC  = 1000;

  logic       i_clk = 1'b0;
  logic       i_rstn;
  logic       i_aclken;
  logic       i_start_test;
  logic       i_stop;
  logic [1:0] i_mode;
  logic [7:0] i_loop_num;
  logic [1:0] i_chk_finished;
  logic [1:0] i_err;
  logic [5:0] i_alm;

  logic        pulse0, busy0, err_any0, to0;
  logic [1:0]  err0;
  logic [15:0] run0, fail0;
  logic        pulse1, busy1, err_any1, to1;
  logic [1:0]  err1;
  logic [1:0]  run1, fail1;

  always #5 i_clk = ~i_clk;

  ipsxb_fft_multi_ch_test_ctrl #(
    .NUM_CH(2), .DB_CNT_MAX(DBM), .DB_CNT_W(5), .GAP_CYCLES(GAPC),
    .TIMEOUT_CYCLES(TOC), .TO_W(10), .LOOP_W(8), .CNT_W(16), .STOP_ON_FAIL(1'b0)
  ) dut0 (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_aclken(i_aclken),
    .i_start_test(i_start_test), .i_stop(i_stop), .i_mode(i_mode),
    .i_loop_num(i_loop_num), .i_chk_finished(i_chk_finished),
    .i_err(i_err), .i_alm(i_alm),
    .o_start_pulse(pulse0), .o_busy(busy0), .o_err(err0),
    .o_err_any(err_any0), .o_timeout(to0), .o_run_cnt(run0), .o_fail_cnt(fail0)
  );

  // Same stimulus, 2-bit counters to show saturation.
  ipsxb_fft_multi_ch_test_ctrl #(
    .NUM_CH(2), .DB_CNT_MAX(DBM), .DB_CNT_W(5), .GAP_CYCLES(GAPC),
    .TIMEOUT_CYCLES(TOC), .TO_W(10), .LOOP_W(8), .CNT_W(2), .STOP_ON_FAIL(1'b0)
  ) dut1 (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_aclken(i_aclken),
    .i_start_test(i_start_test), .i_stop(i_stop), .i_mode(i_mode),
    .i_loop_num(i_loop_num), .i_chk_finished(i_chk_finished),
    .i_err(i_err), .i_alm(i_alm),
    .o_start_pulse(pulse1), .o_busy(busy1), .o_err(err1),
    .o_err_any(err_any1), .o_timeout(to1), .o_run_cnt(run1), .o_fail_cnt(fail1)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- frame checker model ----------------
  int         cyc = 0;
  int         launches = 0;
  int         fin_rise_cyc = 0;
  int         last_gap = 0;
  int         pw_cur = 0;
  int         last_pw = 0;
  int         run_timer = 0;
  bit         running = 0;
  bit         pulse_prev = 0;
  bit         toggle_en = 0;
  bit         hang = 0;
  int         fin_delay = 100;
  int         err_launch = 0;   // 0 none, -1 every launch
  logic [1:0] err_mask = '0;
  logic [5:0] alm_mask = '0;

  initial begin
    i_aclken       = 1'b1;
    i_chk_finished = 2'b11;
    i_err          = '0;
    i_alm          = '0;
    forever begin
      @(posedge i_clk); #1;
      cyc++;
      i_aclken = toggle_en ? ~i_aclken : 1'b1;
      if (pulse0) pw_cur++;
      else if (pw_cur > 0) begin last_pw = pw_cur; pw_cur = 0; end
      if (pulse0 && !pulse_prev) begin
        launches++;
        if (launches > 1) last_gap = cyc - fin_rise_cyc;
        i_chk_finished = 2'b00;
        run_timer = 0;
        running = 1;
      end
      pulse_prev = pulse0;
      i_err = '0;
      i_alm = '0;
      if (running) begin
        run_timer++;
        if ((err_launch == -1 || err_launch == launches) && run_timer >= 5 && run_timer <= 8) begin
          i_err = err_mask;
          i_alm = alm_mask;
        end
        if (!hang && run_timer == fin_delay) begin
          i_chk_finished = 2'b11;
          fin_rise_cyc = cyc;
          running = 0;
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic cycles(input int n);
    repeat (n) begin @(posedge i_clk); #1; end
  endtask

  task automatic do_reset();
    i_rstn = 1'b0;
    cycles(2);
    launches = 0; running = 0; hang = 0; last_gap = 0; last_pw = 0;
    err_launch = 0; err_mask = '0; alm_mask = '0; fin_delay = 100;
    i_chk_finished = 2'b11;
    i_rstn = 1'b1;
    cycles(2);
  endtask

  // Raise the button, count sampled cycles until the launch pulse, release.
  task automatic press(output int lat);
    lat = 0;
    i_start_test = 1'b1;
    while (!pulse0 && lat < 400) begin @(posedge i_clk); #1; lat++; end
    i_start_test = 1'b0;
  endtask

  task automatic wait_idle(input int bound, input string name);
    int n = 0;
    while (busy0 && n < bound) begin @(posedge i_clk); #1; n++; end
    check(name, {31'd0, busy0}, 32'd0);
  endtask

  typedef struct {
    logic [1:0] mode;
    logic [7:0] loop_num;
    int         err_launch;
    logic [1:0] err_mask;
    int         exp_launch;
    int         exp_run;
    int         exp_fail;
    logic [1:0] exp_err;
  } vec_t;

  vec_t vecs[5];
  int   lat;
  int   k;

  initial begin
    // single, clean
    vecs[0] = '{2'b00, 8'd0, 0, 2'b00, 1, 1, 0, 2'b00};
    // mode 11 behaves as single; error on ch1 held after the run
    vecs[1] = '{2'b11, 8'd5, 1, 2'b10, 1, 1, 1, 2'b10};
    // loop of 3, ch1 error in run 2, cleared by launch 3
    vecs[2] = '{2'b01, 8'd3, 2, 2'b10, 3, 3, 1, 2'b00};
    // loop count 0 means one run
    vecs[3] = '{2'b01, 8'd0, 0, 2'b00, 1, 1, 0, 2'b00};
    // loop of 2, ch0 error in the last run stays visible
    vecs[4] = '{2'b01, 8'd2, 2, 2'b01, 2, 2, 1, 2'b01};

    i_stop = 1'b0; i_mode = 2'b00; i_loop_num = '0;

    // Reset with the button already held: no launch must follow.
    i_start_test = 1'b1;
    i_rstn = 1'b0;
    cycles(3);
    i_rstn = 1'b1;
    cycles(30);
    check("rst_launches", launches, 0);
    check("rst_busy", {31'd0, busy0}, 0);
    check("rst_run_cnt", run0, 0);
    check("rst_fail_cnt", fail0, 0);
    check("rst_err", {30'd0, err0}, 0);
    check("rst_timeout", {31'd0, to0}, 0);
    i_start_test = 1'b0;
    cycles(4);

    for (int v = 0; v < 5; v++) begin
      do_reset();
      i_mode = vecs[v].mode;
      i_loop_num = vecs[v].loop_num;
      err_launch = vecs[v].err_launch;
      err_mask = vecs[v].err_mask;
      press(lat);
      // 2 synchroniser cycles + DB_CNT_MAX debounce cycles
      check($sformatf("v%0d_latency", v), lat, DBM + 2);
      wait_idle(2000, $sformatf("v%0d_idle", v));
      cycles(20);
      check($sformatf("v%0d_launches", v), launches, vecs[v].exp_launch);
      check($sformatf("v%0d_run_cnt", v), run0, vecs[v].exp_run);
      check($sformatf("v%0d_fail_cnt", v), fail0, vecs[v].exp_fail);
      check($sformatf("v%0d_err", v), {30'd0, err0}, {30'd0, vecs[v].exp_err});
      check($sformatf("v%0d_err_any", v), {31'd0, err_any0}, {31'd0, |vecs[v].exp_err});
      check($sformatf("v%0d_pulse_w", v), last_pw, 1);
      // finished rise -> EVAL -> GAP_CYCLES -> LAUNCH
      if (vecs[v].exp_launch > 1)
        check($sformatf("v%0d_gap", v), last_gap, GAPC + 2);
    end

    // Stop during debounce cancels the launch.
    do_reset();
    i_mode = 2'b00;
    i_start_test = 1'b1;
    cycles(6);
    i_stop = 1'b1;
    cycles(2);
    i_stop = 1'b0;
    i_start_test = 1'b0;
    cycles(40);
    check("dbstop_launches", launches, 0);
    check("dbstop_busy", {31'd0, busy0}, 0);

    // Timeout: checkers never finish, continuous mode still ends.
    do_reset();
    i_mode = 2'b10;
    hang = 1;
    press(lat);
    k = 0;
    while (!to0 && k < 1500) begin @(posedge i_clk); #1; k++; end
    check("to_latency", k, TOC + 1);
    wait_idle(50, "to_idle");
    cycles(50);
    check("to_flag", {31'd0, to0}, 1);
    check("to_run_cnt", run0, 1);
    check("to_fail_cnt", fail0, 1);
    check("to_launches", launches, 1);
    hang = 0;

    // Continuous with aclken toggling, alarms failing every run,
    // a second button press mid-run, stop during run 5.
    do_reset();
    i_mode = 2'b10;
    toggle_en = 1;
    fin_delay = 40;
    err_launch = -1;
    alm_mask = 6'b000_100;
    press(lat);
    k = 0;
    while (launches < 2 && k < 1000) begin @(posedge i_clk); #1; k++; end
    i_start_test = 1'b1;
    cycles(6);
    i_start_test = 1'b0;
    k = 0;
    while (launches < 5 && k < 3000) begin @(posedge i_clk); #1; k++; end
    check("cont_reach5", launches, 5);
    cycles(10);
    i_stop = 1'b1;
    cycles(6);
    i_stop = 1'b0;
    wait_idle(500, "cont_idle");
    cycles(100);
    check("cont_launches", launches, 5);
    check("cont_run_cnt", run0, 5);
    check("cont_fail_cnt", fail0, 5);
    check("sat_run_cnt", {30'd0, run1}, 3);
    check("sat_fail_cnt", {30'd0, fail1}, 3);
    check("cont_err", {30'd0, err0}, 1);
    check("cont_timeout", {31'd0, to0}, 0);
    // half-rate enable: one enabled cycle spans two clock samples
    check("cont_pulse_w", last_pw, 2);
    toggle_en = 0;
    cycles(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
